// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: credit-limited request issue, redirect flush with
// discard of stale responses, combinational head. Optional perf counters: FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [AWIDTH-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [DWIDTH-1:0] rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_flush_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [AWIDTH-1:0] fetch_pc_r;
  logic [CW-1:0]     osd_r;
  logic [CW-1:0]     discard_r;
  logic [CW-1:0]     count_r;
  logic [PW-1:0]     q_wr_r;
  logic [PW-1:0]     q_rd_r;
  logic [PW-1:0]     opc_wr_r;
  logic [PW-1:0]     opc_rd_r;
  logic [AWIDTH-1:0] q_pc_r   [DEPTH];
  logic [DWIDTH-1:0] q_data_r [DEPTH];
  logic [AWIDTH-1:0] opc_r    [DEPTH];

  logic              credit_s;
  logic              req_valid_s;
  logic              req_fire_s;
  logic              rsp_take_s;
  logic              rsp_drop_s;
  logic              push_s;
  logic              pop_s;
  logic [SW-1:0]     used_s;
  logic [CW-1:0]     osd_nxt_s;
  logic [CW-1:0]     discard_nxt_s;
  logic [CW-1:0]     count_nxt_s;
  logic [AWIDTH-1:0] fetch_pc_nxt_s;

  // Handshake qualification; outstanding count includes requests already doomed by a redirect
  always_comb begin
    used_s      = SW'(count_r) + SW'(osd_r);
    credit_s    = (used_s < SW'(DEPTH));
    req_valid_s = !rst && !redirect_i && credit_s;
    req_fire_s  = req_valid_s && req_ready_i;
    rsp_take_s  = rsp_valid_i && (osd_r != CW'(0));
    rsp_drop_s  = redirect_i || (discard_r != CW'(0));
    push_s      = rsp_take_s && !rsp_drop_s;
    pop_s       = !redirect_i && (count_r != CW'(0)) && insn_ready_i;
  end

  // Next-state for fetch PC, outstanding, discard and occupancy counters
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    osd_nxt_s      = osd_r + CW'(req_fire_s) - CW'(rsp_take_s);
    discard_nxt_s  = discard_r;
    count_nxt_s    = count_r;
    if (redirect_i) begin
      fetch_pc_nxt_s = redirect_pc_i & ~AWIDTH'(3);
      // everything still in flight after this cycle is stale
      discard_nxt_s  = osd_r - CW'(rsp_take_s);
      count_nxt_s    = CW'(0);
    end else begin
      if (req_fire_s) begin
        fetch_pc_nxt_s = fetch_pc_r + AWIDTH'(4);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (rsp_take_s && rsp_drop_s) begin
        discard_nxt_s = discard_r - CW'(1);
      end else begin
        discard_nxt_s = discard_r;
      end
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= BASEADDR;
      osd_r      <= CW'(0);
      discard_r  <= CW'(0);
      count_r    <= CW'(0);
      q_wr_r     <= PW'(0);
      q_rd_r     <= PW'(0);
      opc_wr_r   <= PW'(0);
      opc_rd_r   <= PW'(0);
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      osd_r      <= osd_nxt_s;
      discard_r  <= discard_nxt_s;
      count_r    <= count_nxt_s;
      if (redirect_i) begin
        q_wr_r <= PW'(0);
        q_rd_r <= PW'(0);
      end else begin
        if (push_s) q_wr_r <= q_wr_r + PW'(1);
        if (pop_s)  q_rd_r <= q_rd_r + PW'(1);
      end
      // the PC fifo drains on doomed responses too, keeping it aligned with memory order
      if (req_fire_s) opc_wr_r <= opc_wr_r + PW'(1);
      if (rsp_take_s) opc_rd_r <= opc_rd_r + PW'(1);
    end
  end

  // Queue payload and per-request PC storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]   <= AWIDTH'(0);
        q_data_r[i] <= DWIDTH'(0);
        opc_r[i]    <= AWIDTH'(0);
      end
    end else begin
      if (push_s) begin
        q_pc_r[q_wr_r]   <= opc_r[opc_rd_r];
        q_data_r[q_wr_r] <= rsp_data_i;
      end
      if (req_fire_s) opc_r[opc_wr_r] <= fetch_pc_r;
    end
  end

  assign req_valid_o  = req_valid_s;
  assign req_addr_o   = fetch_pc_r;
  assign insn_valid_o = (count_r != CW'(0));
  assign insn_o       = q_data_r[q_rd_r];
  assign pc_o         = q_pc_r[q_rd_r];

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_flush_r;

  // Delivered-instruction and redirect counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_r <= 32'd0;
      perf_flush_r   <= 32'd0;
    end else begin
      if (pop_s)      perf_fetched_r <= perf_fetched_r + 32'd1;
      if (redirect_i) perf_flush_r   <= perf_flush_r + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_r;
  assign perf_flush_o   = perf_flush_r;
`else
  assign perf_fetched_o = 32'd0;
  assign perf_flush_o   = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory responder plus a queue-based reference model
// checked every cycle, with hand-computed literal checks for the directed scenarios.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        insn_valid_o, insn_ready_i;
  logic [31:0] insn_o, pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] perf_fetched_o, perf_flush_o;

  always #5 clk = ~clk;

  fetch_queue #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .insn_o(insn_o), .pc_o(pc_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .perf_fetched_o(perf_fetched_o), .perf_flush_o(perf_flush_o)
  );

  typedef struct { logic [31:0] pc; bit doom; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] data; int due; } mem_t;

  infl_t       m_infl[$];
  ent_t        m_q[$];
  mem_t        mem[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flush;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat = 1;
  bit   c_req_ready, c_insn_ready, c_redirect;
  logic [31:0] c_redirect_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs, compare against the model, then advance model and memory.
  task automatic evaluate();
    bit    exp_rv;
    infl_t e;
    req_ready_i   = c_req_ready;
    insn_ready_i  = c_insn_ready;
    redirect_i    = c_redirect;
    redirect_pc_i = c_redirect_pc;
    if (mem.size() > 0 && mem[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = mem[0].data;
      void'(mem.pop_front());
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = $urandom;
    end
    #1;
    exp_rv = !c_redirect && ((m_q.size() + m_infl.size()) < DEPTH);
    chk("req_valid", 32'(req_valid_o), 32'(exp_rv));
    chk("req_addr", req_addr_o, m_pc);
    chk("insn_valid", 32'(insn_valid_o), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("insn", insn_o, m_q[0].data);
      chk("pc", pc_o, m_q[0].pc);
    end
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_fetched", perf_fetched_o, m_fetched);
    chk("perf_flush", perf_flush_o, m_flush);
`else
    chk("perf_fetched", perf_fetched_o, 32'd0);
    chk("perf_flush", perf_flush_o, 32'd0);
`endif
    if (req_valid_o && req_ready_i)
      mem.push_back('{data: mem_word(req_addr_o), due: cyc + lat});
    if (c_redirect) begin
      foreach (m_infl[i]) m_infl[i].doom = 1'b1;
      if (rsp_valid_i && m_infl.size() > 0) void'(m_infl.pop_front());
      m_q.delete();
      m_pc = c_redirect_pc & 32'hFFFF_FFFC;
      m_flush = m_flush + 32'd1;
    end else begin
      if (m_q.size() > 0 && c_insn_ready) begin
        void'(m_q.pop_front());
        m_fetched = m_fetched + 32'd1;
      end
      if (rsp_valid_i && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.doom) m_q.push_back('{pc: e.pc, data: rsp_data_i});
      end
      if (exp_rv && c_req_ready) begin
        m_infl.push_back('{pc: m_pc, doom: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    evaluate();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    c_req_ready = 1'b0; c_insn_ready = 1'b0; c_redirect = 1'b0; c_redirect_pc = 32'd0;
    req_ready_i = 1'b0; insn_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    rsp_valid_i = 1'b1; rsp_data_i = 32'hBAD0_BAD0;
    #1;
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("rst_insn_valid", 32'(insn_valid_o), 32'd0);
    chk("rst_perf_fetched", perf_fetched_o, 32'd0);
    chk("rst_perf_flush", perf_flush_o, 32'd0);
    @(negedge clk);
    rsp_valid_i = 1'b0;
    mem.delete(); m_infl.delete(); m_q.delete();
    m_pc = BASE; m_fetched = 32'd0; m_flush = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req_valid", 32'(req_valid_o), 32'd1);
    chk("rel_req_addr", req_addr_o, 32'h0100_0000);
  endtask

  initial begin
    int n;
    int pops;
    logic [7:0] pa;
    logic [4:0] pb;
    pa = 8'b1011_0110;
    pb = 5'b11010;
    req_ready_i = 1'b0; insn_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    rsp_valid_i = 1'b0; rsp_data_i = 32'd0;

    // Streaming: consecutive addresses, one insn per cycle
    do_reset();
    lat = 1; c_req_ready = 1'b1; c_insn_ready = 1'b1;
    tick(); chk("t1_addr0", req_addr_o, 32'h0100_0000);
    tick(); chk("t1_addr1", req_addr_o, 32'h0100_0004);
    tick(); chk("t1_addr2", req_addr_o, 32'h0100_0008);
    chk("t1_pc0", pc_o, 32'h0100_0000);
    chk("t1_insn0", insn_o, 32'h5B5A_C3C3);
    tick(); chk("t1_pc1", pc_o, 32'h0100_0004);
    repeat (12) begin
      tick();
      chk("t1_stream_valid", 32'(insn_valid_o), 32'd1);
    end

    // Fill to DEPTH with consumer stalled, then drain and resume (mid-op reset first)
    do_reset();
    lat = 1; c_req_ready = 1'b1; c_insn_ready = 1'b0;
    repeat (8) tick();
    chk("t2_stall_req", 32'(req_valid_o), 32'd0);
    chk("t2_full_head", pc_o, 32'h0100_0000);
    c_insn_ready = 1'b1;
    tick(); chk("t2_first_pop_noreq", 32'(req_valid_o), 32'd0);
    tick(); chk("t2_resume_valid", 32'(req_valid_o), 32'd1);
    chk("t2_resume_addr", req_addr_o, 32'h0100_0010);
    chk("t2_head_after_pop", pc_o, 32'h0100_0004);
    repeat (10) tick();

    // Redirect with two requests in flight
    do_reset();
    lat = 3; c_req_ready = 1'b1; c_insn_ready = 1'b1;
    tick(); tick();
    c_redirect = 1'b1; c_redirect_pc = 32'h0100_0103;
    tick(); chk("t3_redir_noreq", 32'(req_valid_o), 32'd0);
    c_redirect = 1'b0;
    tick(); chk("t3_new_addr", req_addr_o, 32'h0100_0100);
    n = 0;
    while (!insn_valid_o && n < 20) begin tick(); n++; end
    chk("t3_wait_insn", 32'(n < 20), 32'd1);
    chk("t3_first_pc", pc_o, 32'h0100_0100);
    repeat (6) tick();
    // back-to-back redirects with traffic in flight
    c_redirect = 1'b1; c_redirect_pc = 32'h0200_0000; tick();
    c_redirect_pc = 32'h0300_0008; tick();
    c_redirect = 1'b0;
    tick(); chk("t3_b2b_addr", req_addr_o, 32'h0300_0008);
    repeat (12) tick();

    // Request backpressure holds the address
    do_reset();
    lat = 1; c_req_ready = 1'b0; c_insn_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("t4_hold_addr", req_addr_o, 32'h0100_0000);
      chk("t4_hold_valid", 32'(req_valid_o), 32'd1);
    end
    c_req_ready = 1'b1;
    tick(); chk("t4_hs_addr", req_addr_o, 32'h0100_0000);
    tick(); chk("t4_next_addr", req_addr_o, 32'h0100_0004);

    // Mixed handshake patterns, redirects and address wrap
    lat = 2;
    for (int i = 0; i < 64; i++) begin
      c_req_ready  = pa[i % 8];
      c_insn_ready = pb[i % 5];
      c_redirect   = (i == 20) || (i == 21) || (i == 40);
      c_redirect_pc = (i == 40) ? 32'hFFFF_FFFE : 32'h0100_0400 + 32'(i);
      tick();
      if (i == 41) chk("t5_wrap_addr", req_addr_o, 32'hFFFF_FFFC);
    end
    c_redirect = 1'b0;

    // Counter scenario: exactly 10 pops and 2 redirects
    do_reset();
    lat = 1; c_req_ready = 1'b1; c_insn_ready = 1'b1;
    pops = 0; n = 0;
    while (pops < 10 && n < 60) begin
      tick();
      if (insn_valid_o && insn_ready_i) pops++;
      n++;
    end
    chk("t6_pops", 32'(pops), 32'd10);
    c_insn_ready = 1'b0;
    c_redirect = 1'b1; c_redirect_pc = BASE; tick();
    c_redirect = 1'b0; tick();
    c_redirect = 1'b1; tick();
    c_redirect = 1'b0; tick();
`ifdef FETCH_QUEUE_PERF_EN
    chk("t6_perf_fetched", perf_fetched_o, 32'd10);
    chk("t6_perf_flush", perf_flush_o, 32'd2);
`else
    chk("t6_perf_fetched", perf_fetched_o, 32'd0);
    chk("t6_perf_flush", perf_flush_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction width.
REQ-003 SHALL have parameter BASEADDR, default 32'h01000000, PC after reset.
REQ-004 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: req_valid_o  out  1  fetch request valid; req_ready_i  in  1  memory accepts request; req_addr_o  out  AWIDTH  request address.
REQ-008 SHALL have ports: rsp_valid_i  in  1  response valid; rsp_data_i  in  DWIDTH  instruction word; responses arrive in request order.
REQ-009 SHALL have ports: insn_valid_o  out  1  head valid; insn_ready_i  in  1  consumer takes head; insn_o  out  DWIDTH  head instruction; pc_o  out  AWIDTH  head PC.
REQ-010 SHALL have ports: redirect_i  in  1  flush and re-steer; redirect_pc_i  in  AWIDTH  new PC.
REQ-011 SHALL have ports: perf_fetched_o  out  32  delivered count; perf_flush_o  out  32  redirect count.

Function
REQ-012 SHALL keep a fetch PC; request handshake = req_valid_o && req_ready_i; each handshake advances fetch PC by 4 (wraps modulo 2^AWIDTH).
REQ-013 SHALL drive req_addr_o = fetch PC, with the PC value issued recorded per outstanding request.
REQ-014 SHALL assert req_valid_o only when out of reset, redirect_i low, and (queue count + outstanding) < DEPTH (credit rule; queue never overflows).
REQ-015 SHALL hold req_addr_o stable while req_valid_o high and req_ready_i low.
REQ-016 SHALL push {PC, rsp_data_i} into queue on rsp_valid_i unless that response is marked for discard.
REQ-017 SHALL present head combinationally: insn_valid_o = queue non-empty; pop on insn_valid_o && insn_ready_i.
REQ-018 SHALL allow push and pop in same cycle with count unchanged; full queue with simultaneous pop and push accepted.
REQ-019 SHALL on redirect_i: next cycle queue empty, fetch PC = redirect_pc_i with bits [1:0] forced 0, all currently outstanding requests (including one handshaking this cycle is impossible per REQ-014) marked for discard.
REQ-020 SHALL discard exactly the pre-redirect outstanding count of subsequent responses; a response arriving in the redirect cycle itself is discarded and counted.
REQ-021 SHALL ignore insn_ready_i in the redirect cycle (no pop counted).
REQ-022 SHALL accept back-to-back redirects; discard count accumulates, never exceeding DEPTH.
REQ-023 SHALL first request within 1 cycle after reset deassertion: req_valid_o high, req_addr_o = BASEADDR.
REQ-024 SHALL give zero-bubble throughput: with req_ready_i high, 1-cycle response and insn_ready_i high, one insn delivered per cycle in steady state; response-to-insn_valid_o latency 1 cycle.

Reset
REQ-025 SHALL on rst high, immediately: fetch PC = BASEADDR, queue empty, outstanding = 0, discard = 0, req_valid_o = 0, insn_valid_o = 0, perf counters = 0.
REQ-026 SHALL on reset mid-operation abandon outstanding requests; responses arriving while rst high are ignored; memory side must also reset.

Configuration
REQ-027 SHALL with macro FETCH_QUEUE_PERF_EN defined: perf_fetched_o increments per pop, perf_flush_o per redirect cycle, both wrap at 2^32.
REQ-028 SHALL without FETCH_QUEUE_PERF_EN: perf outputs tied 0, no counter registers; all other behaviour identical.

Verification
REQ-029 Reset release, req_ready_i=1, 1-cycle response, insn_ready_i=1 -> addresses 0x01000000,0x01000004,0x01000008 issued on consecutive cycles; insn_o/pc_o pairs match in order, one per cycle.
REQ-030 insn_ready_i=0, DEPTH=4 -> after 4 responses req_valid_o stays 0; count=4; raise insn_ready_i -> 4 pops then requests resume at 0x01000010.
REQ-031 Two outstanding requests, redirect_i=1 with redirect_pc_i=0x01000103 -> next request 0x01000100; next two responses dropped; third delivered with pc_o=0x01000100.
REQ-032 req_ready_i held low 3 cycles -> req_addr_o stable at same value, PC advances only after handshake.
REQ-033 Full queue, pop and push same cycle -> insn_valid_o stays 1, count stays 4, order preserved.
REQ-034 FETCH_QUEUE_PERF_EN defined, 10 pops and 2 redirects -> perf_fetched_o=10, perf_flush_o=2; undefined -> both 0.
